ref_mem_reader: RTL and testbench

- Read engine for the single-port reference-coordinate RAMs (32-bit words, 2-cycle registered read).
- On a start pulse it issues one read per cycle over a contiguous address range and tracks the RAM read latency.
- It presents returned words on a valid/ready stream with full backpressure support.
- It sits between a reference-position RAM and the force pipeline's particle-fetch logic; it never writes the RAM.

---
 rtl/ref_mem_reader_if.sv | 34 +++
 rtl/ref_mem_reader.sv | 168 ++++++++++++++++
 tb/tb_ref_mem_reader.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_mem_reader_if.sv
// Control, RAM-port and output-stream signals of the reference RAM reader.
// Ports: start/start_addr/num_words/busy/done, mem_*, out_* (master = reader).
interface ref_mem_reader_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [31:0]           mem_q;
  logic [31:0]           out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, start_addr, num_words,
    input  mem_q, out_ready,
    output busy, done,
    output mem_address, mem_rden, mem_wren,
    output out_data, out_valid
  );

  modport slave (
    output start, start_addr, num_words,
    output mem_q, out_ready,
    input  busy, done,
    input  mem_address, mem_rden, mem_wren,
    input  out_data, out_valid
  );
endinterface

// File: rtl/ref_mem_reader.sv
// Streams a contiguous range of a 2-cycle-latency RAM out on valid/ready.
// Ports: clock, rst (async, active-high), bus (ref_mem_reader_if.master).
module ref_mem_reader #(
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic              clock,
  input logic              rst,
  ref_mem_reader_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic                    mem_rden_q, mem_rden_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [PW:0]             in_flight_q, in_flight_d;
  logic [31:0]             fifo_q [FIFO_DEPTH];
  logic [31:0]             fifo_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;

  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [CW-1:0]           credit;

  always_comb begin
    push          = vld_q[READ_LATENCY-1];
    pop           = (count_q != '0) && bus.out_ready;
    // Occupancy after this edge if nothing new issues; a pop this
    // cycle frees its slot in time for a back-to-back read.
    credit        = CW'(in_flight_q) + CW'(count_q) - CW'(pop);
    issue         = 1'b0;
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    mem_address_d = mem_address_q;
    mem_rden_d    = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_words == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = bus.start_addr;
            remaining_d = bus.num_words;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit < CW'(FIFO_DEPTH)) begin
          issue         = 1'b1;
          mem_rden_d    = 1'b1;
          mem_address_d = addr_q;
          // Wrap at DEPTH, which need not be a power of two.
          if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            addr_d = '0;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish on the handshake of the very last word.
        if (in_flight_q == '0 && count_q == (PW + 1)'(1) && pop) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Valid bits ride alongside the read so the tail lines up with mem_q.
    vld_d[0] = mem_rden_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // Counts reads from issue until their data enters the FIFO.
    in_flight_d = in_flight_q + (PW + 1)'(issue) - (PW + 1)'(push);

    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_q;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      mem_address_q <= '0;
      mem_rden_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      vld_q         <= '0;
      in_flight_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      mem_address_q <= mem_address_d;
      mem_rden_q    <= mem_rden_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      vld_q         <= vld_d;
      in_flight_q   <= in_flight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign bus.mem_address = mem_address_q;
  assign bus.mem_rden    = mem_rden_q;
  assign bus.mem_wren    = 1'b0;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = fifo_q[rd_ptr_q];

  no_fifo_overflow: assert property (
    @(posedge clock) disable iff (rst)
    !(push && !pop && count_q == (PW + 1)'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_ref_mem_reader.sv
// Directed bench for ref_mem_reader against a 2-cycle registered RAM model.
// Each task drives one scenario and checks its own results inline.
module tb_ref_mem_reader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ref_mem_reader_if #(.ADDR_WIDTH(9)) bus ();

  ref_mem_reader #(
    .DEPTH(512),
    .ADDR_WIDTH(9),
    .READ_LATENCY(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [512];
  logic [31:0] ram_r1;
  logic [31:0] ram_q;

  always @(posedge clk) begin
    if (bus.mem_rden) ram_r1 <= mem[bus.mem_address];
    ram_q <= ram_r1;
  end

  assign bus.mem_q = ram_q;

  int          cyc = 0;
  logic [31:0] got[$];
  int          hs_cyc[$];
  int          addrs[$];
  int          n_rden;
  int          done_cnt;
  int          done_cyc;
  int          first_rden;
  int          first_valid;
  int          max_out;
  int          stall_viol;
  bit          wren_seen;
  bit          prev_stall;
  logic [31:0] prev_data;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int outst;
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.mem_rden) begin
        n_rden++;
        addrs.push_back(int'(bus.mem_address));
        if (first_rden < 0) first_rden = cyc;
      end
      outst = n_rden - got.size();
      if (outst > max_out) max_out = outst;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data))
        stall_viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        hs_cyc.push_back(cyc);
      end
      if (bus.mem_wren !== 1'b0) wren_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    got.delete();
    hs_cyc.delete();
    addrs.delete();
    n_rden      = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    first_rden  = -1;
    first_valid = -1;
    max_out     = 0;
    stall_viol  = 0;
    wren_seen   = 1'b0;
    prev_stall  = 1'b0;
  endtask

  task automatic do_start(input int a, input int n);
    bus.start_addr = 9'(a);
    bus.num_words  = 10'(n);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic run_until_done(input int mode, input int budget,
                                output bit timed_out);
    int d0;
    d0 = done_cnt;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != d0) begin
        timed_out = 1'b0;
        break;
      end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.num_words  = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
    else n_pass++;
    n_total++;
    if (bus.mem_address !== 9'd0)
      $display("FAIL reset_addr got %0d want 0", bus.mem_address);
    else n_pass++;
    n_total++;
    if (bus.mem_rden !== 1'b0)
      $display("FAIL reset_rden got %b want 0", bus.mem_rden);
    else n_pass++;
    n_total++;
    if (bus.mem_wren !== 1'b0)
      $display("FAIL reset_wren got %b want 0", bus.mem_wren);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_data !== 32'd0)
      $display("FAIL reset_data got %h want 0", bus.out_data);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_stream();
    bit to;
    clear_log();
    do_start(0, 8);
    run_until_done(0, 100, to);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (to) $display("FAIL stream_timeout done not seen");
    else n_pass++;
    n_total++;
    if (got.size() != 8)
      $display("FAIL stream_count got %0d want 8", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== 32'h1000 + i)
        $display("FAIL stream_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, 32'h1000 + i);
      else n_pass++;
    end
    n_total++;
    if (!(hs_cyc.size() == 8 && hs_cyc[7] - hs_cyc[0] == 7))
      $display("FAIL stream_b2b got %0d handshakes not on 8 consecutive cycles",
               hs_cyc.size());
    else n_pass++;
    n_total++;
    if (first_valid - first_rden != 3)
      $display("FAIL stream_latency got %0d want 3", first_valid - first_rden);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL stream_done_cnt got %0d want 1", done_cnt);
    else n_pass++;
    n_total++;
    if (!(hs_cyc.size() > 0 && done_cyc == hs_cyc[hs_cyc.size()-1] + 1))
      $display("FAIL stream_done_time got cycle %0d want last handshake+1",
               done_cyc);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL stream_busy_end got %b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    int ea[4];
    ea = '{510, 511, 0, 1};
    clear_log();
    do_start(510, 4);
    run_until_done(0, 100, to);
    n_total++;
    if (to) $display("FAIL wrap_timeout done not seen");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= addrs.size() || addrs[i] != ea[i])
        $display("FAIL wrap_addr%0d got %0d want %0d", i,
                 (i < addrs.size()) ? addrs[i] : -1, ea[i]);
      else n_pass++;
      n_total++;
      if (i >= got.size() || got[i] !== 32'h1000 + ea[i])
        $display("FAIL wrap_data%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, 32'h1000 + ea[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_log();
    do_start(32, 16);
    run_until_done(1, 400, to);
    n_total++;
    if (to) $display("FAIL bp_timeout done not seen");
    else n_pass++;
    n_total++;
    if (got.size() != 16) $display("FAIL bp_count got %0d want 16", got.size());
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== 32'h1020 + i)
        $display("FAIL bp_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, 32'h1020 + i);
      else n_pass++;
    end
    n_total++;
    if (max_out > 4) $display("FAIL bp_credit got %0d want <=4", max_out);
    else n_pass++;
    n_total++;
    if (stall_viol != 0)
      $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL bp_done_cnt got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_zero();
    clear_log();
    do_start(5, 0);
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL zero_done got %b want 1", bus.done);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL zero_busy got %b want 0", bus.busy);
    else n_pass++;
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (n_rden != 0) $display("FAIL zero_rden got %0d reads want 0", n_rden);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL zero_done_cnt got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_log();
    do_start(200, 6);
    @(posedge clk);
    #1;
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL swb_busy got %b want 1", bus.busy);
    else n_pass++;
    do_start(0, 2);
    run_until_done(0, 100, to);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (to) $display("FAIL swb_timeout done not seen");
    else n_pass++;
    n_total++;
    if (got.size() != 6) $display("FAIL swb_count got %0d want 6", got.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== 32'h10C8 + i)
        $display("FAIL swb_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, 32'h10C8 + i);
      else n_pass++;
    end
    n_total++;
    if (n_rden != 6) $display("FAIL swb_rden got %0d want 6", n_rden);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL swb_done_cnt got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_log();
    do_start(0, 10);
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (got.size() >= 5) begin
        to = 1'b0;
        break;
      end
    end
    n_total++;
    if (to) $display("FAIL rmid_wait got %0d words want 5", got.size());
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.mem_rden !== 1'b0)
      $display("FAIL rmid_rden got %b want 0", bus.mem_rden);
    else n_pass++;
    n_total++;
    if (bus.mem_address !== 9'd0)
      $display("FAIL rmid_addr got %0d want 0", bus.mem_address);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rmid_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_data !== 32'd0)
      $display("FAIL rmid_data got %h want 0", bus.out_data);
    else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL rmid_done got %b want 0", bus.done);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    repeat (8) @(posedge clk);
    #1;
    n_total++;
    if (got.size() != 0 || n_rden != 0)
      $display("FAIL rmid_stale got %0d words %0d reads want 0 0",
               got.size(), n_rden);
    else n_pass++;
    do_start(100, 3);
    run_until_done(0, 100, to);
    n_total++;
    if (to) $display("FAIL rmid_timeout done not seen");
    else n_pass++;
    n_total++;
    if (got.size() != 3) $display("FAIL rmid_count got %0d want 3", got.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== 32'h1064 + i)
        $display("FAIL rmid_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, 32'h1064 + i);
      else n_pass++;
    end
  endtask

  task automatic test_full_range();
    bit to;
    clear_log();
    do_start(0, 512);
    run_until_done(2, 6000, to);
    n_total++;
    if (to) $display("FAIL full_timeout done not seen");
    else n_pass++;
    n_total++;
    if (got.size() != 512) $display("FAIL full_count got %0d want 512", got.size());
    else n_pass++;
    for (int i = 0; i < 512; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== mem[i])
        $display("FAIL full_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, mem[i]);
      else n_pass++;
    end
    n_total++;
    if (wren_seen) $display("FAIL full_wren got 1 want 0");
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL full_done_cnt got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000 + i;
    clear_log();
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_zero();
    test_start_while_busy();
    test_reset_mid();
    test_full_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
